// File: rtl/vector_cfg_loader_if.sv
// Vector RAM port bundle: a PARALLELISM-lane request side (master) and a ready return (slave).
// Latency: none, wires only.
// Backpressure: the slave holds ready low to stall; the master keeps valid and payload stable meanwhile.
interface vector_ram_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4
);
    logic                                   write;
    logic                                   valid;
    logic                                   rready;
    logic                                   ready;
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;

    modport master (
        output write, valid, rready, addr, wdata,
        input  ready
    );

    modport slave (
        input  write, valid, rready, addr, wdata,
        output ready
    );
endinterface

// File: rtl/vector_cfg_loader.sv
// Streams PARALLELISM-wide beats into sequential vector RAM writes (addr 0..LENGTH-1), then pulses done/swap_req.
// Latency: 1 cycle from beat to cfg write; BEATS+3 cycles from start to done when nothing stalls.
// Backpressure: single output register, so in_ready drops only while cfg holds a beat that is not being taken.
// Optional in_last framing checks are enabled by defining VECTOR_CFG_LOADER_LAST_CHECK_EN.
module vector_cfg_loader #(
    parameter int LENGTH      = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ADDR_WIDTH  = $clog2(LENGTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   swap_req,
    output logic                                   err,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] in_data,
    input  logic                                   in_last,
    output logic                                   cfg_en,
    vector_ram_if.master                           cfg
);

    localparam int BEATS = LENGTH / PARALLELISM;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic                  beat_acc;
    logic                  beat_ret;
    logic                  cnt_final;
    logic                  last_beat;
    logic                  start_acc;

    assign start_acc = (state == IDLE) && start;
    assign beat_acc  = in_valid && in_ready;
    assign beat_ret  = cfg.valid && cfg.ready;
    assign cnt_final = (beat_cnt == CNT_W'(BEATS - 1));

`ifdef VECTOR_CFG_LOADER_LAST_CHECK_EN
    logic err_q;
    logic frame_err;

    // An early in_last closes the vector immediately; a missing one on the final beat is only flagged.
    assign last_beat = cnt_final || in_last;
    assign frame_err = (in_last != cnt_final);
    assign err       = err_q;

    // Sticky framing error, cleared when a new load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (beat_acc && frame_err) begin
            err_q <= 1'b1;
        end
    end
`else
    logic last_unused;

    // Without framing checks the beat count alone ends the vector.
    assign last_unused = in_last;
    assign last_beat   = cnt_final;
    assign err         = 1'b0;
`endif

    assign cfg.rready = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the combinational handshake/status outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        cfg_en    = (state != IDLE);
        in_ready  = (state == LOAD) && (!cfg.valid || cfg.ready);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (beat_acc && last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!cfg.valid || beat_ret) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat counter and element base address for the next accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            base     <= '0;
        end else if (start_acc) begin
            beat_cnt <= '0;
            base     <= '0;
        end else if (beat_acc) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            base     <= base + ADDR_WIDTH'(PARALLELISM);
        end
    end

    // Output register: load on accept, hold while stalled, empty on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.valid <= 1'b0;
            cfg.write <= 1'b0;
            cfg.addr  <= '0;
            cfg.wdata <= '0;
        end else if (beat_acc) begin
            cfg.valid <= 1'b1;
            cfg.write <= 1'b1;
            cfg.wdata <= in_data;
            for (int i = 0; i < PARALLELISM; i++) begin
                cfg.addr[i] <= base + ADDR_WIDTH'(i);
            end
        end else if (beat_ret) begin
            cfg.valid <= 1'b0;
            cfg.write <= 1'b0;
        end
    end

    // Completion pulses, registered so they land as busy falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            swap_req <= 1'b0;
        end else begin
            done     <= (state == DONE);
            swap_req <= (state == DONE) && !err;
        end
    end

endmodule

// File: tb/tb_vector_cfg_loader.sv
// Directed bench for vector_cfg_loader with LENGTH=16, PARALLELISM=4.
// Each load is checked for done/swap timing, err, per-address write counts and data, and payload stability under stall.
// Expectations for framing cases follow VECTOR_CFG_LOADER_LAST_CHECK_EN.
module tb_vector_cfg_loader;

    localparam int LENGTH = 16;
    localparam int DW     = 32;
    localparam int P      = 4;
    localparam int AW     = 4;
    localparam int BEATS  = LENGTH / P;

`ifdef VECTOR_CFG_LOADER_LAST_CHECK_EN
    localparam bit CHECKS_ON = 1'b1;
`else
    localparam bit CHECKS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                busy;
    logic                done;
    logic                swap_req;
    logic                err;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [P-1:0][DW-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                cfg_en;

    vector_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLELISM(P)) cfg_bus ();

    vector_cfg_loader #(
        .LENGTH(LENGTH), .DATA_WIDTH(DW), .PARALLELISM(P), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .swap_req(swap_req), .err(err), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .cfg_en(cfg_en), .cfg(cfg_bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt [LENGTH];
    logic [DW-1:0] wr_dat [LENGTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " swap_req"}, swap_req, 0);
        check({name, " err"}, err, 0);
        check({name, " in_ready"}, in_ready, 0);
        check({name, " cfg_en"}, cfg_en, 0);
        check({name, " valid"}, cfg_bus.valid, 0);
        check({name, " write"}, cfg_bus.write, 0);
        check({name, " rready"}, cfg_bus.rready, 0);
        for (int i = 0; i < P; i++) begin
            check($sformatf("%s addr[%0d]", name, i), cfg_bus.addr[i], 0);
            check($sformatf("%s wdata[%0d]", name, i), cfg_bus.wdata[i], 0);
        end
    endtask

    // One load: start at cycle T, then observe cycles T+1..T+20 at the falling edge.
    task automatic run_load(input string name, input int tag, input int last_idx, input bit stall,
                            input int restart_k, input int abort_k, input int exp_done,
                            input bit exp_err, input bit exp_swap, input int exp_words);
        int b = 0;
        int n_done = 0;
        int done_k = -1;
        int n_swap = 0;
        int swap_k = -1;
        bit held = 1'b0;
        logic [P-1:0][AW-1:0] h_addr;
        logic [P-1:0][DW-1:0] h_dat;
        for (int a = 0; a < LENGTH; a++) begin
            wr_cnt[a] = 0;
            wr_dat[a] = '0;
        end
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        cfg_bus.ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                start = 1'b0;
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_vals({name, " async"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            start = (k == restart_k);
            cfg_bus.ready = stall ? (k % 2 == 1) : 1'b1;
            in_valid = (b < BEATS);
            in_last = (b == last_idx);
            for (int i = 0; i < P; i++) begin
                in_data[i] = DW'((tag << 8) + b * P + i);
            end
            #1;
            if (k == 1) begin
                check({name, " busy@T+1"}, busy, 1);
                check({name, " cfg_en@T+1"}, cfg_en, 1);
                check({name, " in_ready@T+1"}, in_ready, 1);
            end
            if (held) begin
                check({name, " stall valid held"}, cfg_bus.valid, 1);
                check({name, " stall addr held"}, cfg_bus.addr, h_addr);
                check({name, " stall data0 held"}, cfg_bus.wdata[0], h_dat[0]);
                check({name, " stall data3 held"}, cfg_bus.wdata[3], h_dat[3]);
            end
            held = cfg_bus.valid && !cfg_bus.ready;
            h_addr = cfg_bus.addr;
            h_dat = cfg_bus.wdata;
            if (held) begin
                check({name, " in_ready while stalled"}, in_ready, 0);
            end
            if (cfg_bus.valid && cfg_bus.ready) begin
                for (int i = 0; i < P; i++) begin
                    wr_cnt[cfg_bus.addr[i]]++;
                    wr_dat[cfg_bus.addr[i]] = cfg_bus.wdata[i];
                end
            end
            if (in_valid && in_ready) begin
                b++;
            end
            if (done) begin
                n_done++;
                if (done_k < 0) begin
                    done_k = k;
                    check({name, " busy at done"}, busy, 0);
                end
            end
            if (swap_req) begin
                n_swap++;
                swap_k = k;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check({name, " done pulses"}, n_done, 1);
        check({name, " done cycle"}, done_k, exp_done);
        check({name, " swap pulses"}, n_swap, exp_swap);
        if (exp_swap) begin
            check({name, " swap cycle"}, swap_k, done_k);
        end
        check({name, " err"}, err, exp_err);
        for (int a = 0; a < LENGTH; a++) begin
            check($sformatf("%s writes@%0d", name, a), wr_cnt[a], (a < exp_words) ? 1 : 0);
            if (a < exp_words) begin
                check($sformatf("%s data@%0d", name, a), wr_dat[a], DW'((tag << 8) + a));
            end
        end
    endtask

    initial begin
        cfg_bus.ready = 1'b1;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_load("basic", 1, 3, 1'b0, -1, -1, 7, 1'b0, 1'b1, 16);
        run_load("stall", 2, 3, 1'b1, -1, -1, 11, 1'b0, 1'b1, 16);
        if (CHECKS_ON) begin
            run_load("early_last", 3, 1, 1'b0, -1, -1, 5, 1'b1, 1'b0, 8);
        end else begin
            run_load("early_last", 3, 1, 1'b0, -1, -1, 7, 1'b0, 1'b1, 16);
        end
        run_load("restart", 4, 3, 1'b0, 2, -1, 7, 1'b0, 1'b1, 16);
        run_load("abort", 5, 3, 1'b0, -1, 3, 0, 1'b0, 1'b0, 0);
        run_load("after_rst", 6, 3, 1'b0, -1, -1, 7, 1'b0, 1'b1, 16);
        if (CHECKS_ON) begin
            run_load("no_last", 7, -1, 1'b0, -1, -1, 7, 1'b1, 1'b0, 16);
        end else begin
            run_load("no_last", 7, -1, 1'b0, -1, -1, 7, 1'b0, 1'b1, 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_cfg_loader.md
# vector_cfg_loader

Streaming loader that sits directly upstream of the vector ping-pong load wrapper and drives its `cfg` port and `cfg_en`. It accepts a valid/ready stream of PARALLELISM-wide data beats and turns them into sequential vector RAM writes covering addresses 0..LENGTH-1. The writes land in the bank not currently used by compute. On completion it pulses `swap_req` so the iteration controller toggles `ping`.

## Interface
- LENGTH, 1024: vector length in elements; must be a multiple of PARALLELISM.
- DATA_WIDTH, 32: element width.
- PARALLELISM, 4: elements per beat and number of cfg lanes.
- ADDR_WIDTH, $clog2(LENGTH): element address width.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write is accepted.
- swap_req  out  1  one-cycle pulse, same cycle as done; suppressed on error.
- err  out  1  sticky framing error, cleared by the next accepted start.
- in_valid  in  1  stream beat valid.
- in_ready  out  1  stream beat accepted when in_valid && in_ready.
- in_data  in  PARALLELISM x DATA_WIDTH  beat data, lane i = element base+i.
- in_last  in  1  marks final beat of the vector.
- cfg_en  out  1  selects cfg as the write source for the inactive bank.
- cfg  vector_ram_if.master  -  drives write, valid, rready, addr[], wdata[]; consumes ready.

## Operation
- Beats per vector: BEATS = LENGTH/PARALLELISM. Beat counter width is $clog2(BEATS)+1.
- FSM states:
  - IDLE: on start, clear err and the counters, then go to LOAD.
  - LOAD: accept beats into the output register. When the final beat (count BEATS-1) is accepted, go to DRAIN.
  - DRAIN: wait for cfg to accept the held beat, then go to DONE.
  - DONE: pulse done (and swap_req if !err) for one cycle, then go to IDLE.
- Each accepted beat latches the following:
  - cfg.addr[i] = base + i.
  - cfg.wdata[i] = in_data[i].
  - cfg.write = 1, cfg.valid = 1, cfg.rready = 0.
  - base then increments by PARALLELISM; ADDR_WIDTH arithmetic, no wrap needed.
- cfg.valid stays high and its payload stays stable until cfg.ready. A beat is retired on cfg.valid && cfg.ready.
- in_ready = (state == LOAD) && (!cfg.valid || cfg.ready). This is a single-register pipeline that still sustains one beat per cycle.
- cfg_en = busy. It rises the cycle after start is accepted and falls the cycle after DONE.
- Framing:
  - in_last on a beat other than the final one: set err and treat that beat as final (go to DRAIN early).
  - No in_last on the final beat: set err, load completes normally.
- start while busy: ignored, no effect.
- Reset mid-load: all state returns to IDLE immediately. The partially written bank is undefined, and no done or swap_req is produced.

## Timing
- Reset values: busy 0, done 0, swap_req 0, err 0, in_ready 0, cfg_en 0, cfg.valid 0, cfg.write 0, cfg.rready 0, addr and wdata all zero.
- start accepted at cycle T:
  - busy and cfg_en are high from T+1.
  - in_ready can be high from T+1.
- Beat accepted at cycle N: cfg.valid is high at N+1. Input-to-cfg latency is 1 cycle.
- Best-case load (cfg.ready tied high, in_valid always high): BEATS+3 cycles from start to the done pulse.
- Each cycle cfg.ready is low adds one cycle of latency. No beat is lost or duplicated.
- done and swap_req are registered and assert for exactly one cycle. busy falls in the same cycle done asserts.

## Configuration
- VECTOR_CFG_LOADER_LAST_CHECK_EN:
  - Defined: in_last framing checks are active and err is driven as described above.
  - Undefined: in_last is ignored and err is tied to 0. The load always ends after exactly BEATS beats, and swap_req always accompanies done.

## Test plan
- LENGTH=16, PARALLELISM=4, cfg.ready=1, beats 0x00..0x0F with in_last on beat 3 -> addr groups 0-3, 4-7, 8-11, 12-15 carry the matching data; done and swap_req pulse at cycle start+7; err=0.
- Same load with cfg.ready low on alternate cycles -> every beat is written exactly once with payload held stable while stalled; done at start+11.
- in_last on beat 1 (macro defined) -> only addr 0-7 are written, err=1, done pulses, swap_req stays 0.
- start pulsed during LOAD -> ignored; base address continues unchanged.
- rst_n asserted after 2 beats -> all outputs take their reset values asynchronously; the next start writes from addr 0 again.
- Macro undefined, in_last never asserted -> 4 beats written, err=0, swap_req=1.
